mem_stage_lsu: RTL and testbench



---
 rtl/mem_stage_lsu_if.sv | 28 ++
 rtl/mem_stage_lsu.sv | 196 +++++++++++++++++++
 tb/tb_mem_stage_lsu.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_stage_lsu_if.sv
// Data-memory bus between the MEMORY-stage LSU (master) and the memory (slave).
// Handshake: the master raises o_MemReq with o_MemAddr/o_MemWe/o_MemWData/o_MemBe
// stable; the transfer is accepted on the first rising edge where i_MemGnt is
// high while o_MemReq is high. For reads, i_MemRValid marks the single cycle in
// which i_MemRData carries the raw word; it never coincides with the grant.
interface mem_stage_lsu_if #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 32
);
  logic                      o_MemReq;
  logic                      o_MemWe;
  logic [ADDRESS_WIDTH-1:0]  o_MemAddr;
  logic [DATA_WIDTH-1:0]     o_MemWData;
  logic [DATA_WIDTH/8-1:0]   o_MemBe;
  logic                      i_MemGnt;
  logic                      i_MemRValid;
  logic [DATA_WIDTH-1:0]     i_MemRData;

  modport master (
    output o_MemReq, o_MemWe, o_MemAddr, o_MemWData, o_MemBe,
    input  i_MemGnt, i_MemRValid, i_MemRData
  );

  modport slave (
    input  o_MemReq, o_MemWe, o_MemAddr, o_MemWData, o_MemBe,
    output i_MemGnt, i_MemRValid, i_MemRData
  );
endinterface

// File: rtl/mem_stage_lsu.sv
// MEMORY-stage load/store unit: issues one request per access on the data bus,
// stalls the pipeline until it completes, formats sub-word stores and aligns /
// extends sub-word loads. Byte-lane logic assumes a 32-bit data bus.
// Optional feature macro: LSU_MISALIGN_TRAP_EN (trap misaligned half/word
// accesses instead of silently dropping the low address bits).
module mem_stage_lsu #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 32
) (
  input  logic                     i_CLK,
  input  logic                     i_RST,
  input  logic [ADDRESS_WIDTH-1:0] i_ALUOutM,
  input  logic [DATA_WIDTH-1:0]    i_WriteDataM,
  input  logic                     i_MemWriteM,
  input  logic                     i_MemReadM,
  input  logic [1:0]               i_SizeM,
  input  logic                     i_SignedM,
  output logic [DATA_WIDTH-1:0]    o_ReadDataM,
  output logic                     o_StallM,
  output logic                     o_MisalignM,
  output logic [1:0]               o_DbgState,
  mem_stage_lsu_if.master          bus
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_REQ    = 2'd1,
    S_WAIT_R = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t                    state_q, state_d;
  logic [ADDRESS_WIDTH-1:0]  addr_q, addr_d;
  logic [1:0]                size_q, size_d;
  logic                      signed_q, signed_d;
  logic                      we_q, we_d;
  logic                      req_q, req_d;
  logic [DATA_WIDTH-1:0]     wdata_q, wdata_d;
  logic [DATA_WIDTH/8-1:0]   be_q, be_d;
  logic [DATA_WIDTH-1:0]     rdata_q, rdata_d;
  logic [DATA_WIDTH/8-1:0]   be_fmt;
  logic [DATA_WIDTH-1:0]     wdata_fmt;
  logic [DATA_WIDTH-1:0]     load_ext;
  logic [7:0]                byte_lane;
  logic [15:0]               half_lane;
  logic                      access;

`ifdef LSU_MISALIGN_TRAP_EN
  logic                      mis_q, mis_d;
  logic                      misaligned;
  // Half needs a[0]=0, word (size 10/11) needs a[1:0]=0.
  assign misaligned = ((i_SizeM == 2'b01) && i_ALUOutM[0]) ||
                      (i_SizeM[1] && (i_ALUOutM[1:0] != 2'b00));
  assign o_MisalignM = mis_q;
`else
  assign o_MisalignM = 1'b0;
`endif

  // Both flags high is treated as a write.
  assign access = i_MemReadM | i_MemWriteM;

  // Byte enables and lane-replicated store data from the current stage inputs.
  always_comb begin
    be_fmt    = 4'b1111;
    wdata_fmt = i_WriteDataM;
    case (i_SizeM)
      2'b00: begin
        be_fmt    = 4'b0001 << i_ALUOutM[1:0];
        wdata_fmt = {4{i_WriteDataM[7:0]}};
      end
      2'b01: begin
        be_fmt    = 4'b0011 << {i_ALUOutM[1], 1'b0};
        wdata_fmt = {2{i_WriteDataM[15:0]}};
      end
      default: begin
        be_fmt    = 4'b1111;
        wdata_fmt = i_WriteDataM;
      end
    endcase
  end

  // Select the addressed lane of the raw read word and extend it.
  always_comb begin
    byte_lane = bus.i_MemRData[7:0];
    case (addr_q[1:0])
      2'd0:    byte_lane = bus.i_MemRData[7:0];
      2'd1:    byte_lane = bus.i_MemRData[15:8];
      2'd2:    byte_lane = bus.i_MemRData[23:16];
      default: byte_lane = bus.i_MemRData[31:24];
    endcase
    half_lane = addr_q[1] ? bus.i_MemRData[31:16] : bus.i_MemRData[15:0];
    case (size_q)
      2'b00:   load_ext = {{24{signed_q & byte_lane[7]}}, byte_lane};
      2'b01:   load_ext = {{16{signed_q & half_lane[15]}}, half_lane};
      default: load_ext = bus.i_MemRData;
    endcase
  end

  // Next-state and registered-output logic of the access FSM.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    size_d   = size_q;
    signed_d = signed_q;
    we_d     = we_q;
    req_d    = req_q;
    wdata_d  = wdata_q;
    be_d     = be_q;
    rdata_d  = rdata_q;
`ifdef LSU_MISALIGN_TRAP_EN
    mis_d    = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (access) begin
          addr_d   = i_ALUOutM;
          size_d   = i_SizeM;
          signed_d = i_SignedM;
          we_d     = i_MemWriteM;
          wdata_d  = wdata_fmt;
          be_d     = be_fmt;
`ifdef LSU_MISALIGN_TRAP_EN
          if (misaligned) begin
            // No bus traffic; flag the exception during the DONE cycle.
            state_d = S_DONE;
            mis_d   = 1'b1;
            if (!i_MemWriteM) rdata_d = '0;
          end else begin
            state_d = S_REQ;
            req_d   = 1'b1;
          end
`else
          state_d = S_REQ;
          req_d   = 1'b1;
`endif
        end
      end
      S_REQ: begin
        if (bus.i_MemGnt) begin
          req_d   = 1'b0;
          state_d = we_q ? S_DONE : S_WAIT_R;
        end
      end
      S_WAIT_R: begin
        if (bus.i_MemRValid) begin
          rdata_d = load_ext;
          state_d = S_DONE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers; reset abandons any access in flight.
  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      size_q   <= '0;
      signed_q <= 1'b0;
      we_q     <= 1'b0;
      req_q    <= 1'b0;
      wdata_q  <= '0;
      be_q     <= '0;
      rdata_q  <= '0;
`ifdef LSU_MISALIGN_TRAP_EN
      mis_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      size_q   <= size_d;
      signed_q <= signed_d;
      we_q     <= we_d;
      req_q    <= req_d;
      wdata_q  <= wdata_d;
      be_q     <= be_d;
      rdata_q  <= rdata_d;
`ifdef LSU_MISALIGN_TRAP_EN
      mis_q    <= mis_d;
`endif
    end
  end

  assign o_StallM       = ~i_RST & access & (state_q != S_DONE);
  assign o_ReadDataM    = rdata_q;
  assign o_DbgState     = state_q;
  assign bus.o_MemReq   = req_q;
  assign bus.o_MemWe    = we_q;
  assign bus.o_MemAddr  = {addr_q[ADDRESS_WIDTH-1:2], 2'b00};
  assign bus.o_MemWData = wdata_q;
  assign bus.o_MemBe    = be_q;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Bench for mem_stage_lsu: directed test-plan accesses, randomized accesses and
// a reset-during-read case, checked against an arithmetic reference model.
`timescale 1ns/1ps
module tb_mem_stage_lsu;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] alu;
  logic [DW-1:0] wdata_in;
  logic          mem_write;
  logic          mem_read;
  logic [1:0]    size;
  logic          sgn;
  logic [DW-1:0] read_data;
  logic          stall;
  logic          misalign;
  logic [1:0]    dbg_state;

  int errors = 0;
  int checks = 0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] model_rdata;

  mem_stage_lsu_if #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) bus ();

  mem_stage_lsu #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) dut (
    .i_CLK       (clk),
    .i_RST       (rst),
    .i_ALUOutM   (alu),
    .i_WriteDataM(wdata_in),
    .i_MemWriteM (mem_write),
    .i_MemReadM  (mem_read),
    .i_SizeM     (size),
    .i_SignedM   (sgn),
    .o_ReadDataM (read_data),
    .o_StallM    (stall),
    .o_MisalignM (misalign),
    .o_DbgState  (dbg_state),
    .bus         (bus)
  );

  // Clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Reference model: plain arithmetic on byte address and size.
  function automatic logic model_mis(input logic [31:0] a, input logic [1:0] sz);
    if (sz == 2'd1) return (a % 2) != 0;
    if (sz >= 2'd2) return (a % 4) != 0;
    return 1'b0;
  endfunction

  function automatic logic [3:0] model_be(input logic [31:0] a, input logic [1:0] sz);
    logic [31:0] v;
    if (sz == 2'd0)      v = 32'd1 << (a % 4);
    else if (sz == 2'd1) v = 32'd3 << (2 * ((a / 2) % 2));
    else                 v = 32'hF;
    return v[3:0];
  endfunction

  function automatic logic [31:0] model_wdata(input logic [31:0] d, input logic [1:0] sz);
    if (sz == 2'd0) return (d & 32'hFF) * 32'h0101_0101;
    if (sz == 2'd1) return (d & 32'hFFFF) * 32'h0001_0001;
    return d;
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] rw, input logic [31:0] a,
                                             input logic [1:0] sz, input logic sg);
    logic [31:0] v;
    if (sz == 2'd0) begin
      v = (rw >> (8 * (a % 4))) & 32'hFF;
      if (sg && v >= 32'h80) v = v | 32'hFFFF_FF00;
    end else if (sz == 2'd1) begin
      v = (rw >> (16 * ((a / 2) % 2))) & 32'hFFFF;
      if (sg && v >= 32'h8000) v = v | 32'hFFFF_0000;
    end else begin
      v = rw;
    end
    return v;
  endfunction

  // Driver + memory responder for one access; ends after the DONE cycle.
  task automatic run_access(input string tag, input logic [31:0] a, input logic [31:0] d,
                            input logic rd, input logic wr, input logic [1:0] sz,
                            input logic sg, input int gnt_dly, input int rv_dly,
                            input logic [31:0] rword);
    logic trap;
    logic done;
    logic saw_wait;
    int stalls;
    int req_cyc;
    int wait_cyc;
    int cyc;
    int exp_stalls;
    logic [31:0] exp_rd;
`ifdef LSU_MISALIGN_TRAP_EN
    trap = model_mis(a, sz);
`else
    trap = 1'b0;
`endif
    done = 1'b0; saw_wait = 1'b0;
    stalls = 0; req_cyc = 0; wait_cyc = 0; cyc = 0;
    if (!wr) exp_q.push_back(trap ? 32'h0 : model_load(rword, a, sz, sg));
    exp_stalls = trap ? 1 : (wr ? 2 + gnt_dly : 3 + gnt_dly + rv_dly);

    @(posedge clk); #1;
    alu = a; wdata_in = d; mem_read = rd; mem_write = wr; size = sz; sgn = sg;
    while (!done && cyc < 64) begin
      @(negedge clk);
      cyc++;
      if (stall) begin
        stalls++;
        if (bus.o_MemReq) begin
          req_cyc++;
          check({tag, ".addr"},  bus.o_MemAddr,  a & 32'hFFFF_FFFC);
          check({tag, ".be"},    {28'h0, bus.o_MemBe}, {28'h0, model_be(a, sz)});
          check({tag, ".we"},    {31'h0, bus.o_MemWe}, {31'h0, wr});
          check({tag, ".wdata"}, bus.o_MemWData, model_wdata(d, sz));
          bus.i_MemGnt    = (req_cyc == gnt_dly + 1);
          bus.i_MemRValid = 1'($urandom_range(0, 1));
          bus.i_MemRData  = $urandom;
        end else if (dbg_state == ST_WAIT) begin
          saw_wait = 1'b1;
          wait_cyc++;
          bus.i_MemGnt    = 1'($urandom_range(0, 1));
          bus.i_MemRValid = (wait_cyc == rv_dly + 1);
          bus.i_MemRData  = (wait_cyc == rv_dly + 1) ? rword : $urandom;
        end else begin
          bus.i_MemGnt    = 1'($urandom_range(0, 1));
          bus.i_MemRValid = 1'($urandom_range(0, 1));
          bus.i_MemRData  = $urandom;
        end
      end else begin
        done = 1'b1;
      end
    end
    if (!done) begin
      check({tag, ".timeout"}, 32'd0, 32'd1);
    end else begin
      check({tag, ".stalls"},   stalls, exp_stalls);
      check({tag, ".req_cyc"},  req_cyc, trap ? 0 : gnt_dly + 1);
      check({tag, ".wait_seen"}, {31'h0, saw_wait}, {31'h0, (!wr && !trap)});
      check({tag, ".state"},    {30'h0, dbg_state}, {30'h0, ST_DONE});
      check({tag, ".misalign"}, {31'h0, misalign}, {31'h0, trap});
      check({tag, ".req_done"}, {31'h0, bus.o_MemReq}, 32'h0);
      if (!wr) model_rdata = exp_q.pop_front();
      check({tag, ".rdata"},    read_data, model_rdata);
    end
    @(posedge clk); #1;
    mem_read = 1'b0; mem_write = 1'b0;
    bus.i_MemGnt = 1'b0; bus.i_MemRValid = 1'b0;
    @(negedge clk);
    check({tag, ".idle_after"}, {30'h0, dbg_state}, {30'h0, ST_IDLE});
    check({tag, ".mis_after"},  {31'h0, misalign}, 32'h0);
  endtask

  initial begin
    logic [31:0] ra;
    logic [31:0] rd_word;
    int op;

    // Reset
    rst = 1'b1; alu = '0; wdata_in = '0; mem_read = 1'b0; mem_write = 1'b0;
    size = 2'd0; sgn = 1'b0;
    bus.i_MemGnt = 1'b0; bus.i_MemRValid = 1'b0; bus.i_MemRData = '0;
    model_rdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst.req",   {31'h0, bus.o_MemReq}, 32'h0);
    check("rst.we",    {31'h0, bus.o_MemWe}, 32'h0);
    check("rst.addr",  bus.o_MemAddr, 32'h0);
    check("rst.wdata", bus.o_MemWData, 32'h0);
    check("rst.be",    {28'h0, bus.o_MemBe}, 32'h0);
    check("rst.rdata", read_data, 32'h0);
    check("rst.mis",   {31'h0, misalign}, 32'h0);
    check("rst.stall", {31'h0, stall}, 32'h0);
    check("rst.state", {30'h0, dbg_state}, {30'h0, ST_IDLE});
    rst = 1'b0;

    // Directed test-plan accesses
    run_access("sb",     32'h103, 32'h0000_00AB, 1'b0, 1'b1, 2'd0, 1'b0, 0, 0, 32'h0);
    run_access("lh_s",   32'h202, 32'h0,         1'b1, 1'b0, 2'd1, 1'b1, 0, 0, 32'h8001_1234);
    run_access("lbu",    32'h201, 32'h0,         1'b1, 1'b0, 2'd0, 1'b0, 3, 0, 32'h0000_F200);
    run_access("rw_both", 32'h40, 32'h1234_5678, 1'b1, 1'b1, 2'd2, 1'b0, 0, 0, 32'h0);
    run_access("lw_mis", 32'h102, 32'h0,         1'b1, 1'b0, 2'd2, 1'b0, 0, 0, 32'hCAFE_F00D);
    run_access("sh_mis", 32'h101, 32'h0000_BEEF, 1'b0, 1'b1, 2'd1, 1'b0, 1, 0, 32'h0);
    run_access("lb_s",   32'h303, 32'h0,         1'b1, 1'b0, 2'd0, 1'b1, 0, 2, 32'h9A00_0000);
    run_access("sw_11",  32'h44,  32'hA5A5_0F0F, 1'b0, 1'b1, 2'd3, 1'b0, 2, 0, 32'h0);

    // Randomized accesses
    for (int i = 0; i < 40; i++) begin
      ra      = $urandom;
      rd_word = $urandom;
      op      = $urandom_range(0, 2);
      run_access("rnd", ra, $urandom, (op != 1), (op != 0), 2'($urandom_range(0, 3)),
                 1'($urandom_range(0, 1)), $urandom_range(0, 3), $urandom_range(0, 3), rd_word);
    end

    // Reset while a load waits for rvalid
    @(posedge clk); #1;
    alu = 32'h300; mem_read = 1'b1; mem_write = 1'b0; size = 2'd2; sgn = 1'b0;
    @(negedge clk);
    check("rstw.idle", {30'h0, dbg_state}, {30'h0, ST_IDLE});
    @(negedge clk);
    check("rstw.req", {31'h0, bus.o_MemReq}, 32'h1);
    bus.i_MemGnt = 1'b1;
    @(negedge clk);
    bus.i_MemGnt = 1'b0;
    check("rstw.wait", {30'h0, dbg_state}, {30'h0, ST_WAIT});
    rst = 1'b1;
    @(negedge clk);
    check("rstw.req0",  {31'h0, bus.o_MemReq}, 32'h0);
    check("rstw.state", {30'h0, dbg_state}, {30'h0, ST_IDLE});
    check("rstw.stall", {31'h0, stall}, 32'h0);
    model_rdata = 32'h0;
    check("rstw.rdata", read_data, model_rdata);
    mem_read = 1'b0; rst = 1'b0;
    @(negedge clk);
    bus.i_MemRValid = 1'b1; bus.i_MemRData = 32'hDEAD_BEEF;
    @(negedge clk);
    bus.i_MemRValid = 1'b0;
    check("rstw.late_rv", read_data, model_rdata);
    check("rstw.state2",  {30'h0, dbg_state}, {30'h0, ST_IDLE});
    check("rstw.req2",    {31'h0, bus.o_MemReq}, 32'h0);
    check("rstw.q_empty", exp_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
